// File: rtl/level_to_pulse_pkg.sv
// Shared definitions for the multi-channel level-to-pulse converter:
// edge-select mode encoding, pulse FSM states and a counter-width helper.
package level_to_pulse_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } pulse_state_e;

  // A counter that must hold n-1 needs at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/level_to_pulse_channel.sv
// One channel: synchroniser chain, debouncer that accepts a level change after
// DEBOUNCE_CYCLES consecutive differing samples, and a Moore pulse FSM.
module level_to_pulse_channel
  import level_to_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         level,
  input  logic [1:0]   mode,
  output logic         pulse,
  output logic         stable,
  output logic         overrun,
  output pulse_state_e state
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int PW = cnt_width(PULSE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  pulse_state_e           state_q, state_d;
  logic                   overrun_q, overrun_d;

  logic s;
  logic accept;
  logic rise_en, fall_en;
  logic edge_event;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = '0;
    sync_d[0] = level;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Any sample that agrees with the debounced level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept   = 1'b1;
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (mode)
      MODE_OFF:  ;
      MODE_RISE: rise_en = 1'b1;
      MODE_FALL: fall_en = 1'b1;
      MODE_BOTH: begin
        rise_en = 1'b1;
        fall_en = 1'b1;
      end
      default: ;
    endcase
    edge_event = accept & ((s & rise_en) | (~s & fall_en));
  end

  // Events arriving while a pulse is running (final cycle included) are dropped.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (edge_event) begin
          state_d = PULSE;
          pcnt_d  = PCNT_LAST;
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
        if (edge_event) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      state_q   <= IDLE;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  assign pulse   = (state_q == PULSE);
  assign stable  = stable_q;
  assign overrun = overrun_q;
  assign state   = state_q;

endmodule

// File: rtl/level_to_pulse_multi.sv
// CHANNELS independent level-to-pulse converters; this level only slices ports.
// Dbg_state bit i is high while channel i's pulse FSM is in its PULSE state.
module level_to_pulse_multi
  import level_to_pulse_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [CHANNELS-1:0]   Level,
  input  logic [2*CHANNELS-1:0] Mode,
  output logic [CHANNELS-1:0]   Pulse,
  output logic [CHANNELS-1:0]   Stable,
  output logic [CHANNELS-1:0]   Overrun,
  output logic [CHANNELS-1:0]   Dbg_state
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_state_e ch_state;

    level_to_pulse_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES)
    ) u_ch (
      .clk     (Clock),
      .rst     (Reset),
      .level   (Level[i]),
      .mode    (Mode[2*i +: 2]),
      .pulse   (Pulse[i]),
      .stable  (Stable[i]),
      .overrun (Overrun[i]),
      .state   (ch_state)
    );

    assign Dbg_state[i] = (ch_state == PULSE);
  end

endmodule
